// File: rtl/bcd_to_binary_seq_pkg.sv
// Package bcd2bin_pkg: shared types and constants for the BCD-to-binary converter.
//   state_t         - converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_MAX   - largest legal BCD digit
//   BCD_ADJ_THRESH  - nibble value at or above which the shift-right correction applies
//   BCD_ADJ_VAL     - correction subtracted from a nibble after each right shift
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Interface bcd_to_binary_seq_if: request/result bundle of the BCD-to-binary converter.
// Handshake: the requester raises start with bcd_in valid; the converter accepts it on
// the first clock edge at which it is idle (start is not queued while busy). busy is high
// while shifting; done pulses for one cycle with bin_out and err valid; bin_out and err
// then hold until the next accepted start.
//   start   requester -> converter   conversion request
//   bcd_in  requester -> converter   packed BCD, digit 0 in [3:0]
//   bin_out converter -> requester   binary result
//   busy    converter -> requester   conversion in progress
//   done    converter -> requester   one-cycle completion pulse
//   err     converter -> requester   error flag of the last conversion
//   state   converter -> requester   FSM state, for observation only
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) ();
    import bcd2bin_pkg::*;

    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;
    state_t                state;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err, state
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err, state
    );

endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Module bcd_sub3: per-nibble correction for reverse double-dabble.
// After a right shift a BCD nibble that reads 8 or more has received a bit worth 10
// from the digit above but counts it as 8; subtracting 3 makes it 5 as required.
//   d  input  4  nibble after the shift
//   q  output 4  corrected nibble
module bcd_sub3
    import bcd2bin_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? (d - BCD_ADJ_VAL) : d;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Module bcd_to_binary_seq: multi-cycle packed-BCD to unsigned binary converter.
// Shifts the {bcd, bin} register right one bit per clock and corrects every BCD
// nibble that reads 8 or more by -3; after BIN_W shifts the low BIN_W bits hold the
// binary value. A request containing a digit above 9 completes immediately with err=1.
// Optional build macro BCD2BIN_OVF_CHECK_EN: also flag err when the value does not fit
// in BIN_W bits (nonzero BCD residue); otherwise the result is silently truncated.
// Ports:
//   CLOCK_50  input   system clock, rising edge
//   reset     input   asynchronous active-high reset
//   bus       slave   start/bcd_in request, bin_out/busy/done/err/state result
module bcd_to_binary_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    bcd_to_binary_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_next;
    logic [CNT_W-1:0]   count;
    logic [DIGITS-1:0]  nib_bad;
    logic [BIN_W-1:0]   bin_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    assign sr_shift = sr >> 1;
    assign sr_next[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        bcd_sub3 u_sub3 (
            .d (sr_shift[BIN_W + 4*g +: 4]),
            .q (sr_next[BIN_W + 4*g +: 4])
        );
        assign nib_bad[g] = bus.bcd_in[4*g +: 4] > BCD_DIGIT_MAX;
    end

`ifdef BCD2BIN_OVF_CHECK_EN
    // Anything left in the BCD part after the last shift is value >= 2^BIN_W.
    logic residue_nz;
    assign residue_nz = |sr_next[SR_W-1:BIN_W];
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            count  <= '0;
            bin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                        if (|nib_bad) begin
                            bin_q  <= '0;
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            sr     <= {bus.bcd_in, {BIN_W{1'b0}}};
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= CONV;
                        end
                    end
                end
                CONV: begin
                    sr    <= sr_next;
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        // This edge performs the final shift; publish its result directly.
                        bin_q  <= sr_next[BIN_W-1:0];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef BCD2BIN_OVF_CHECK_EN
                        err_q  <= residue_nz;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.state   = state;

endmodule
